// File: rtl/mux_ctrl_scheduler_if.sv
// mux_ctrl_scheduler_if
//   Groups the scheduler's enable/request inputs and its select outputs.
//   master : request side (drives i_en, i_req; observes the grant outputs)
//   slave  : scheduler side (consumes i_en, i_req; drives o_ctrl, o_valid, o_switch)
//   Signals:
//     i_en     1  scheduler enable
//     i_req    4  per-channel request, bit k requests channel k
//     o_ctrl   2  granted channel index, feeds the selector's i_ctrl
//     o_valid  1  high while a grant is active
//     o_switch 1  one-cycle pulse on the first cycle of each new grant
interface mux_ctrl_scheduler_if;
   logic       i_en;
   logic [3:0] i_req;
   logic [1:0] o_ctrl;
   logic       o_valid;
   logic       o_switch;

   modport master (
      output i_en, i_req,
      input  o_ctrl, o_valid, o_switch
   );

   modport slave (
      input  i_en, i_req,
      output o_ctrl, o_valid, o_switch
   );
endinterface

// File: rtl/mux_ctrl_scheduler.sv
// mux_ctrl_scheduler
//   Round-robin select generator for a clocked 4:1 data selector. Grants one
//   requesting channel at a time for DWELL cycles, then rotates to the next
//   requesting channel after the current one. All outputs are registered.
//   Parameters:
//     DWELL  cycles each grant is held (1..255)
//   Ports:
//     i_clk  clock, rising edge
//     i_rst  asynchronous active-high reset
//     bus    mux_ctrl_scheduler_if.slave (i_en, i_req in; o_ctrl, o_valid, o_switch out)
module mux_ctrl_scheduler #(
   parameter int DWELL = 4
) (
   input  logic                  i_clk,
   input  logic                  i_rst,
   mux_ctrl_scheduler_if.slave   bus
);

   localparam int CNT_W = $clog2(DWELL + 1);
   localparam logic [CNT_W-1:0] DWELL_M1 = CNT_W'(DWELL - 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   typedef enum logic {
      S_IDLE  = 1'b0,
      S_GRANT = 1'b1
   } state_t;

   state_t           state_q;
   logic [1:0]       ctrl_q;
   logic             valid_q;
   logic             switch_q;
   logic [1:0]       last_q;
   logic [CNT_W-1:0] cnt_q;

   // Arbitration result for the current request vector.
   logic [1:0] arb_ch_d;
   logic       arb_any_d;
   logic       found;
   logic [1:0] idx;

   // Scan last+1 .. last+4 (mod 4); the 2-bit add provides the wrap, and the
   // fourth step lands back on last so the current owner wins only when it is
   // the sole requester.
   // NOTE: every signal written here gets a default first so the block stays
   // purely combinational (no latches).
   always_comb begin
      arb_any_d = |bus.i_req;
      arb_ch_d  = last_q;
      found     = 1'b0;
      idx       = last_q;
      for (int i = 1; i <= 4; i++) begin
         idx = last_q + 2'(i);
         if (!found && bus.i_req[idx]) begin
            arb_ch_d = idx;
            found    = 1'b1;
         end
      end
   end

   // NOTE: the reset is in the sensitivity list, so it clears the outputs
   // immediately rather than waiting for a clock edge.
   // NOTE: registered state uses non-blocking assignments so every flop samples
   // the pre-edge values of its neighbours.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state_q  <= S_IDLE;
         ctrl_q   <= 2'b00;
         valid_q  <= 1'b0;
         switch_q <= 1'b0;
         last_q   <= 2'b11;   // first arbitration favours channel 0
         cnt_q    <= '0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (bus.i_en && arb_any_d) begin
                  state_q  <= S_GRANT;
                  ctrl_q   <= arb_ch_d;
                  last_q   <= arb_ch_d;
                  cnt_q    <= DWELL_M1;
                  valid_q  <= 1'b1;
                  switch_q <= 1'b1;
               end else begin
                  valid_q  <= 1'b0;
                  switch_q <= 1'b0;
               end
            end

            S_GRANT: begin
               if (!bus.i_en) begin
                  // Enable drop aborts the grant regardless of the dwell count.
                  state_q  <= S_IDLE;
                  valid_q  <= 1'b0;
                  switch_q <= 1'b0;
               end else if (!bus.i_req[ctrl_q] || cnt_q == '0) begin
                  if (!arb_any_d) begin
                     state_q  <= S_IDLE;
                     valid_q  <= 1'b0;
                     switch_q <= 1'b0;
                  end else if (arb_ch_d != ctrl_q) begin
                     ctrl_q   <= arb_ch_d;
                     last_q   <= arb_ch_d;
                     cnt_q    <= DWELL_M1;
                     switch_q <= 1'b1;
                  end else begin
                     // Sole requester keeps the grant without a new switch pulse.
                     cnt_q    <= DWELL_M1;
                     switch_q <= 1'b0;
                  end
               end else begin
                  cnt_q    <= cnt_q - CNT_ONE;
                  switch_q <= 1'b0;
               end
            end

            default: begin
               state_q  <= S_IDLE;
               valid_q  <= 1'b0;
               switch_q <= 1'b0;
            end
         endcase
      end
   end

   assign bus.o_ctrl   = ctrl_q;
   assign bus.o_valid  = valid_q;
   assign bus.o_switch = switch_q;

endmodule

// File: tb/tb_mux_ctrl_scheduler.sv
// tb_mux_ctrl_scheduler
//   Drives two scheduler instances (DWELL=4 and DWELL=1) with identical
//   directed stimulus. A behavioural model per instance, counting served
//   cycles per grant, is compared against the DUT on every falling edge;
//   literal expectations pin the model for each scenario.
module tb_mux_ctrl_scheduler;

   localparam int DW_A = 4;
   localparam int DW_B = 1;

   logic       clk;
   logic       rst;
   logic       en;
   logic [3:0] req;

   int n_checks = 0;
   int n_pass   = 0;

   mux_ctrl_scheduler_if if_a ();
   mux_ctrl_scheduler_if if_b ();

   assign if_a.i_en  = en;
   assign if_a.i_req = req;
   assign if_b.i_en  = en;
   assign if_b.i_req = req;

   mux_ctrl_scheduler #(.DWELL(DW_A)) dut_a (.i_clk(clk), .i_rst(rst), .bus(if_a.slave));
   mux_ctrl_scheduler #(.DWELL(DW_B)) dut_b (.i_clk(clk), .i_rst(rst), .bus(if_b.slave));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input int act, input int exp);
      n_checks++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
   endtask

   // ---------------- behavioural model ----------------
   int dwell [2] = '{DW_A, DW_B};
   bit m_act [2];
   bit m_sw  [2];
   int m_ch  [2];
   int m_last[2];
   int m_used[2];   // cycles of the current grant already served

   function automatic int pick(input int last, input logic [3:0] r);
      for (int i = 1; i <= 4; i++)
         if (r[(last + i) % 4]) return (last + i) % 4;
      return -1;
   endfunction

   task automatic model_step(input int k);
      int w;
      w = pick(m_last[k], req);
      if (!m_act[k]) begin
         if (en && req != 4'b0) begin
            m_act[k] = 1; m_ch[k] = w; m_last[k] = w; m_used[k] = 1; m_sw[k] = 1;
         end else m_sw[k] = 0;
      end else if (!en) begin
         m_act[k] = 0; m_sw[k] = 0;
      end else if (!req[m_ch[k]] || m_used[k] == dwell[k]) begin
         if (req == 4'b0) begin
            m_act[k] = 0; m_sw[k] = 0;
         end else if (w != m_ch[k]) begin
            m_ch[k] = w; m_last[k] = w; m_used[k] = 1; m_sw[k] = 1;
         end else begin
            m_used[k] = 1; m_sw[k] = 0;
         end
      end else begin
         m_used[k]++; m_sw[k] = 0;
      end
   endtask

   always @(posedge clk or posedge rst) begin
      for (int k = 0; k < 2; k++) begin
         if (rst) begin
            m_act[k] = 0; m_sw[k] = 0; m_ch[k] = 0; m_last[k] = 3; m_used[k] = 0;
         end else model_step(k);
      end
   end

   // ---------------- per-cycle compare ----------------
   always @(negedge clk) begin
      check("cmp_a_ctrl",   int'(if_a.o_ctrl),   m_ch[0]);
      check("cmp_a_valid",  int'(if_a.o_valid),  int'(m_act[0]));
      check("cmp_a_switch", int'(if_a.o_switch), int'(m_sw[0]));
      check("cmp_b_ctrl",   int'(if_b.o_ctrl),   m_ch[1]);
      check("cmp_b_valid",  int'(if_b.o_valid),  int'(m_act[1]));
      check("cmp_b_switch", int'(if_b.o_switch), int'(m_sw[1]));
   end

   task automatic idle_cycle();
      en = 1'b0; req = 4'b0000;
      @(negedge clk);
      check("idle_a_valid", int'(if_a.o_valid), 0);
   endtask

   // ---------------- directed stimulus ----------------
   initial begin
      rst = 1'b1; en = 1'b0; req = 4'b0000;
      #1;
      check("rst_a_ctrl",   int'(if_a.o_ctrl),   0);
      check("rst_a_valid",  int'(if_a.o_valid),  0);
      check("rst_a_switch", int'(if_a.o_switch), 0);
      @(negedge clk); @(negedge clk);
      rst = 1'b0;
      @(negedge clk);

      // Full rotation, all four requesting.
      en = 1'b1; req = 4'b1111;
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         check("rot_a_ctrl",   int'(if_a.o_ctrl),   i / 4);
         check("rot_a_switch", int'(if_a.o_switch), int'(i % 4 == 0));
         check("rot_a_valid",  int'(if_a.o_valid),  1);
         check("rot_b_ctrl",   int'(if_b.o_ctrl),   i % 4);
         check("rot_b_switch", int'(if_b.o_switch), 1);
      end

      // Sparse requests with wrap: A restarts from last=2 so 3 comes first.
      idle_cycle();
      en = 1'b1; req = 4'b1001;
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         check("wrap_a_ctrl",   int'(if_a.o_ctrl),   ((i / 4) % 2 == 0) ? 3 : 0);
         check("wrap_a_switch", int'(if_a.o_switch), int'(i % 4 == 0));
      end

      // Sole requester holds the grant with a single switch pulse.
      idle_cycle();
      en = 1'b1; req = 4'b0100;
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         check("sole_a_ctrl",   int'(if_a.o_ctrl),   2);
         check("sole_a_valid",  int'(if_a.o_valid),  1);
         check("sole_a_switch", int'(if_a.o_switch), int'(i == 0));
         check("sole_b_switch", int'(if_b.o_switch), int'(i == 0));
      end

      // Early drop of channel 1 in its 2nd dwell cycle, then enable abort.
      idle_cycle();
      en = 1'b1; req = 4'b0010;
      @(negedge clk);
      check("drop_a_ctrl1", int'(if_a.o_ctrl),   1);
      check("drop_a_sw1",   int'(if_a.o_switch), 1);
      req = 4'b1010;
      @(negedge clk);
      check("drop_a_ctrl2", int'(if_a.o_ctrl),   1);
      check("drop_a_sw2",   int'(if_a.o_switch), 0);
      req = 4'b1000;
      @(negedge clk);
      check("drop_a_ctrl3", int'(if_a.o_ctrl),   3);
      check("drop_a_sw3",   int'(if_a.o_switch), 1);
      en = 1'b0;
      @(negedge clk);
      check("abort_a_valid", int'(if_a.o_valid), 0);
      check("abort_a_ctrl",  int'(if_a.o_ctrl),  3);

      // DWELL=1 toggling between channels 1 and 2.
      en = 1'b1; req = 4'b0110;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         check("d1_b_ctrl",   int'(if_b.o_ctrl),   (i % 2 == 0) ? 1 : 2);
         check("d1_b_switch", int'(if_b.o_switch), 1);
         check("d1_a_ctrl",   int'(if_a.o_ctrl),   (i < 4) ? 1 : 2);
      end

      // Asynchronous reset in the middle of a grant on channel 2.
      req = 4'b0100;
      @(negedge clk);
      check("pre_rst_a_ctrl",  int'(if_a.o_ctrl),  2);
      check("pre_rst_a_valid", int'(if_a.o_valid), 1);
      #2 rst = 1'b1;
      #1;
      check("arst_a_ctrl",   int'(if_a.o_ctrl),   0);
      check("arst_a_valid",  int'(if_a.o_valid),  0);
      check("arst_a_switch", int'(if_a.o_switch), 0);
      check("arst_b_valid",  int'(if_b.o_valid),  0);
      @(negedge clk);
      rst = 1'b0; en = 1'b1; req = 4'b0001;
      @(negedge clk);
      check("post_rst_a_ctrl",   int'(if_a.o_ctrl),   0);
      check("post_rst_a_valid",  int'(if_a.o_valid),  1);
      check("post_rst_a_switch", int'(if_a.o_switch), 1);
      @(negedge clk);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/mux_ctrl_scheduler.md
# mux_ctrl_scheduler

Round-robin select generator that drives the 2-bit control input of the clocked 4:1 16-bit data selector. It watches four per-channel request lines and grants one channel at a time for a fixed dwell of DWELL cycles. It then rotates fairly to the next requesting channel. Its registered o_ctrl connects directly to the selector's i_ctrl. o_valid and o_switch tell downstream logic when the selected data is meaningful and when the selection changed.

## Interface
- DWELL, 4: cycles each grant is held; legal range 1..255; counter width is $clog2(DWELL+1).
- i_clk  input  1  clock, rising-edge.
- i_rst  input  1  reset, asynchronous, active-high.
- i_en  input  1  scheduler enable; low forces return to IDLE.
- i_req  input  4  per-channel request; bit k requests channel k.
- o_ctrl  output  2  selected channel index, to selector i_ctrl.
- o_valid  output  1  high while a grant is active.
- o_switch  output  1  one-cycle pulse in the first cycle of every new grant.

## Operation
- Two states: IDLE and GRANT. The internal last-granted pointer `last` is 2 bits wide. The dwell counter is `cnt`.
- Reset values: state=IDLE, o_ctrl=2'b00, o_valid=0, o_switch=0, last=2'b11, cnt=0. With last=3, the first arbitration favours channel 0.
- Arbitration function: scan channels (last+1), (last+2), (last+3), (last+4) mod 4, and pick the first with i_req set. Wrap-around is modulo 4, so channel 3 is followed by channel 0. The current channel is chosen again only if it is the sole requester.
- IDLE:
  - If i_en=1 and i_req≠0, arbitrate. Then set o_ctrl=winner, last=winner, cnt=DWELL-1, o_valid=1, o_switch=1, and move to GRANT.
  - Otherwise stay in IDLE with o_valid=0 and o_switch=0. o_ctrl holds its last value.
- GRANT, priority order:
  1. If i_en=0, go to IDLE next cycle with o_valid=0. This aborts the grant regardless of cnt.
  2. If i_req[o_ctrl]=0 (requester dropped) or cnt=0 (dwell expired), re-arbitrate:
     - If i_req=0, go to IDLE.
     - If the winner differs from o_ctrl, load the new grant and pulse o_switch.
     - If the winner equals o_ctrl, reload cnt=DWELL-1 and keep o_switch=0.
  3. Otherwise decrement cnt; o_switch=0.
- DWELL=1: cnt is always 0, so the grant rotates every cycle when several channels request.
- Simultaneous requests from all four channels produce the strict sequence 0,1,2,3,0,... with DWELL cycles per channel.
- Requests arriving for non-granted channels mid-dwell never pre-empt the current grant.

## Timing
- All outputs are registered; there is no combinational input-to-output path.
- Grant latency: request sampled at edge n gives o_valid/o_ctrl/o_switch at edge n+1 (one cycle).
- Selected data latency: the selector registers its output. Data for channel o_ctrl therefore appears on its o_data one edge after o_ctrl changes.
- Grant length: exactly DWELL cycles of o_valid per grant when the request stays asserted.
- Back-to-back grants have no idle cycle between them.
- Request drop: drop sampled at edge n gives the new grant or IDLE at edge n+1.
- Reset asserted mid-grant clears all outputs immediately (asynchronous).
- Reset release: the first grant can occur at the first rising edge at which i_rst is low and a request is sampled.

## Test plan
- Reset: assert i_rst mid-GRANT with o_ctrl=2 -> o_ctrl=0, o_valid=0, o_switch=0 immediately. After release with i_req=4'b0001 and i_en=1 -> o_ctrl=0 and o_valid=1 one edge later.
- Full rotation: DWELL=4, i_req=4'b1111, i_en=1 -> o_ctrl runs 0,0,0,0,1,1,1,1,2,... with o_switch high only on the first cycle of each group.
- Sparse/wrap: i_req=4'b1001 -> grants alternate 0 and 3, 4 cycles each. After channel 3 the next grant is 0.
- Sole requester: i_req=4'b0100 for 12 cycles -> o_ctrl=2 continuously, o_valid=1, o_switch pulses once at grant start only.
- Early drop and enable abort: i_req[1] drops in the 2nd dwell cycle while i_req[3]=1 -> o_ctrl=3 with o_switch=1 next edge. Then i_en=0 -> o_valid=0 next edge, o_ctrl held at 3.
- DWELL=1 with i_req=4'b0110 -> o_ctrl toggles 1,2,1,2 every cycle, with o_switch high every cycle.
